// File: rtl/pio_out_timed_pkg.sv
// rtl/pio_out_timed_pkg.sv - register map and shared types for the timed output PIO
package pio_out_timed_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLR    = 3'd2;
    localparam logic [2:0] ADDR_TMASK  = 3'd3;
    localparam logic [2:0] ADDR_PERIOD = 3'd4;
    localparam logic [2:0] ADDR_CTRL   = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;

    localparam int CTRL_RUN     = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_IRQEN   = 2;
    localparam int STATUS_TICK  = 0;

    typedef enum logic {
        TMR_IDLE = 1'b0,
        TMR_RUN  = 1'b1
    } tmr_state_e;

endpackage

// File: rtl/pio_period_timer.sv
// rtl/pio_period_timer.sv - reloading down-counter producing periodic or one-shot ticks
module pio_period_timer
    import pio_out_timed_pkg::*;
#(
    parameter int CNT_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ctrl_we,
    input  logic                 run_wdata,
    input  logic                 oneshot,
    input  logic [CNT_WIDTH-1:0] period,
    output logic                 run,
    output logic                 tick
);

    tmr_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TMR_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tick    = 1'b0;
        case (state_q)
            TMR_IDLE: begin
                if (ctrl_we && run_wdata) begin
                    state_d = TMR_RUN;
                    cnt_d   = period;
                end
            end
            TMR_RUN: begin
                if (cnt_q == '0) begin
                    tick  = 1'b1;
                    cnt_d = period;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
                // A tick in the same cycle as a stop request is still emitted
                if ((tick && oneshot) || (ctrl_we && !run_wdata)) begin
                    state_d = TMR_IDLE;
                end
            end
            default: state_d = TMR_IDLE;
        endcase
    end

    assign run = (state_q == TMR_RUN);

endmodule

// File: rtl/pio_out_timed.sv
// rtl/pio_out_timed.sv - Avalon-MM output PIO with set/clear access and timed masked toggling
module pio_out_timed
    import pio_out_timed_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    CNT_WIDTH   = 24,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [DATA_WIDTH-1:0] tmask_q;
    logic [CNT_WIDTH-1:0]  period_q;
    logic                  oneshot_q, irq_en_q;
    logic                  flag_q, flag_d;
    logic                  irq_q;
    logic                  run, tick;

    logic                  wr_en;
    logic                  we_data, we_set, we_clr, we_tmask, we_period, we_ctrl, we_status;
    logic [DATA_WIDTH-1:0] wdata;

    assign wr_en     = chipselect && !write_n;
    assign we_data   = wr_en && (address == ADDR_DATA);
    assign we_set    = wr_en && (address == ADDR_SET);
    assign we_clr    = wr_en && (address == ADDR_CLR);
    assign we_tmask  = wr_en && (address == ADDR_TMASK);
    assign we_period = wr_en && (address == ADDR_PERIOD);
    assign we_ctrl   = wr_en && (address == ADDR_CTRL);
    assign we_status = wr_en && (address == ADDR_STATUS);
    assign wdata     = writedata[DATA_WIDTH-1:0];

    pio_period_timer #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_timer (
        .clk      (clk),
        .rst_n    (reset_n),
        .ctrl_we  (we_ctrl),
        .run_wdata(writedata[CTRL_RUN]),
        .oneshot  (oneshot_q),
        .period   (period_q),
        .run      (run),
        .tick     (tick)
    );

    // Bus writes to the output register override that cycle's toggle
    always_comb begin
        data_out_d = data_out_q;
        if (tick) begin
            data_out_d = data_out_q ^ tmask_q;
        end
        if (we_data) begin
            data_out_d = wdata;
        end else if (we_set) begin
            data_out_d = data_out_q | wdata;
        end else if (we_clr) begin
            data_out_d = data_out_q & ~wdata;
        end
    end

    always_comb begin
        flag_d = flag_q;
        if (tick) begin
            flag_d = 1'b1;
        end else if (we_status && writedata[STATUS_TICK]) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= RESET_VALUE;
            tmask_q    <= '0;
            period_q   <= '0;
            oneshot_q  <= 1'b0;
            irq_en_q   <= 1'b0;
            flag_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            flag_q     <= flag_d;
            irq_q      <= flag_q && irq_en_q;
            if (we_tmask) begin
                tmask_q <= wdata;
            end
            if (we_period) begin
                period_q <= writedata[CNT_WIDTH-1:0];
            end
            if (we_ctrl) begin
                oneshot_q <= writedata[CTRL_ONESHOT];
                irq_en_q  <= writedata[CTRL_IRQEN];
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata = 32'(data_out_q);
            ADDR_TMASK:  readdata = 32'(tmask_q);
            ADDR_PERIOD: readdata = 32'(period_q);
            ADDR_CTRL:   readdata = {29'b0, irq_en_q, oneshot_q, run};
            ADDR_STATUS: readdata = {31'b0, flag_q};
            default:     readdata = '0;
        endcase
    end

    assign out_port = data_out_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_pio_out_timed.sv
// tb/tb_pio_out_timed.sv - scoreboard bench for pio_out_timed
module tb_pio_out_timed;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        irq;

    always #5 clk = ~clk;

    pio_out_timed #(
        .DATA_WIDTH (8),
        .CNT_WIDTH  (24),
        .RESET_VALUE(8'hA5)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .irq       (irq)
    );

    // kind 0 = readdata, 1 = out_port, 2 = irq
    typedef struct {
        int          kind;
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                0:       act = readdata;
                1:       act = {24'b0, out_port};
                default: act = {31'b0, irq};
            endcase
            total++;
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic exp_push(input int k, input string n, input logic [31:0] v);
        exp_t e;
        e.kind = k;
        e.name = n;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic chk_rd(input logic [2:0] a, input logic [31:0] v, input string n);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        exp_push(0, n, v);
        @(posedge clk);
        #1;
        chipselect = 1'b0;
    endtask

    task automatic chk_port(input logic [7:0] v, input string n);
        exp_push(1, n, {24'b0, v});
    endtask

    task automatic chk_irq(input logic v, input string n);
        exp_push(2, n, {31'b0, v});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    initial begin
        // reset state
        step(2);
        chk_port(8'hA5, "rst_port_in_reset");
        step(1);
        reset_n = 1'b1;
        step(1);
        chk_port(8'hA5, "rst_port");
        chk_irq(1'b0, "rst_irq");
        chk_rd(3'd0, 32'hA5, "rst_data");
        chk_rd(3'd1, 32'h0, "rst_set");
        chk_rd(3'd2, 32'h0, "rst_clr");
        chk_rd(3'd3, 32'h0, "rst_tmask");
        chk_rd(3'd4, 32'h0, "rst_period");
        chk_rd(3'd5, 32'h0, "rst_ctrl");
        chk_rd(3'd6, 32'h0, "rst_status");
        chk_rd(3'd7, 32'h0, "rst_rsvd");

        // data / set / clear
        bus_wr(3'd0, 32'h0F);
        chk_port(8'h0F, "wr_data");
        bus_wr(3'd1, 32'h30);
        chk_port(8'h3F, "wr_set");
        bus_wr(3'd2, 32'h05);
        chk_port(8'h3A, "wr_clr");
        chk_rd(3'd1, 32'h0, "rd_set_zero");
        chk_rd(3'd0, 32'h3A, "rd_data");
        bus_wr(3'd0, 32'hFFFF_FF12);
        chk_rd(3'd0, 32'h12, "rd_data_upper_ignored");
        bus_wr(3'd4, 32'hFFFF_FFFF);
        chk_rd(3'd4, 32'h00FF_FFFF, "rd_period_width");

        // free-running, period 3
        bus_wr(3'd0, 32'h0);
        bus_wr(3'd3, 32'h1);
        bus_wr(3'd4, 32'd3);
        bus_wr(3'd5, 32'h1);
        chk_port(8'h00, "fr_start");
        step(3);
        chk_port(8'h00, "fr_before_tick1");
        step(1);
        chk_port(8'h01, "fr_tick1");
        step(4);
        chk_port(8'h00, "fr_tick2");
        step(4);
        chk_port(8'h01, "fr_tick3");
        chk_irq(1'b0, "fr_irq_disabled");
        chk_rd(3'd6, 32'h1, "fr_status");
        bus_wr(3'd5, 32'h0);
        bus_wr(3'd6, 32'h1);
        chk_rd(3'd6, 32'h0, "fr_status_cleared");
        step(8);
        chk_port(8'h01, "fr_stopped");

        // one-shot with irq, period 9
        bus_wr(3'd0, 32'h0);
        bus_wr(3'd4, 32'd9);
        bus_wr(3'd5, 32'h7);
        step(9);
        chk_port(8'h00, "os_before");
        chk_irq(1'b0, "os_irq_before");
        step(1);
        chk_port(8'h01, "os_tick");
        chk_irq(1'b0, "os_irq_lag");
        step(1);
        chk_irq(1'b1, "os_irq_rise");
        chk_rd(3'd5, 32'h6, "os_ctrl_run_cleared");
        chk_rd(3'd6, 32'h1, "os_status");
        step(15);
        chk_port(8'h01, "os_single_toggle");
        bus_wr(3'd6, 32'h1);
        chk_irq(1'b1, "os_irq_hold");
        step(1);
        chk_irq(1'b0, "os_irq_fall");
        bus_wr(3'd5, 32'h0);

        // period 1 with bus/tick collisions
        bus_wr(3'd0, 32'h0);
        bus_wr(3'd4, 32'd1);
        bus_wr(3'd5, 32'h1);
        step(1);
        bus_wr(3'd1, 32'h80);
        chk_port(8'h80, "col_set_wins");
        step(2);
        chk_port(8'h81, "col_next_tick");
        step(1);
        bus_wr(3'd6, 32'h1);
        chk_port(8'h80, "col_status_tick_toggle");
        chk_rd(3'd6, 32'h1, "col_flag_set_wins");
        bus_wr(3'd5, 32'h0);
        chk_port(8'h81, "col_stop_tick_honoured");
        chk_rd(3'd5, 32'h0, "col_stopped");
        step(5);
        chk_port(8'h81, "col_idle_hold");
        bus_wr(3'd6, 32'h1);
        chk_rd(3'd6, 32'h0, "col_flag_clear");

        // asynchronous reset mid-run
        bus_wr(3'd0, 32'h3C);
        bus_wr(3'd3, 32'hFF);
        bus_wr(3'd4, 32'd100);
        bus_wr(3'd5, 32'h5);
        step(50);
        chk_port(8'h3C, "ar_before");
        step(1);
        reset_n = 1'b0;
        chk_port(8'hA5, "ar_async_port");
        chk_irq(1'b0, "ar_async_irq");
        step(3);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(20);
            chk_port(8'hA5, "ar_no_tick");
        end
        chk_rd(3'd6, 32'h0, "ar_status");
        chk_rd(3'd5, 32'h0, "ar_ctrl");
        chk_rd(3'd4, 32'h0, "ar_period");
        chk_rd(3'd3, 32'h0, "ar_tmask");

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pio_out_timed.md
# pio_out_timed

Parametrised Avalon-MM output PIO for the QSYS system, succeeding the single-bit SMA output port. It provides a DATA_WIDTH-bit output register with atomic set/clear access and a programmable period timer that toggles a masked subset of output bits on each expiry. Toggling runs in free-running or one-shot mode and raises a sticky flag with an optional interrupt. It sits on the system interconnect as an `s1` slave and drives board pins such as SMA, GPIO and LEDs.

## Interface
- DATA_WIDTH, 8, output port width (1..32)
- CNT_WIDTH, 24, period counter width (2..32)
- RESET_VALUE, 0, reset value of out_port (DATA_WIDTH bits)
- clk  input  1  system clock
- reset_n  input  1  reset; one clock domain, reset asynchronous and active-low
- address  input  3  register select
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe
- writedata  input  32  write data
- readdata  output  32  read data, combinational from address, zero-extended
- out_port  output  DATA_WIDTH  output register contents
- irq  output  1  tick_flag & irq_en, registered

## Operation
- A write occurs on `chipselect && !write_n`. Reads have no side effects.
- Register map:
  - 0 DATA (rw): full write of data_out.
  - 1 SET (wo): data_out |= writedata.
  - 2 CLR (wo): data_out &= ~writedata.
  - 3 TMASK (rw): bits toggled on each tick.
  - 4 PERIOD (rw, CNT_WIDTH bits): tick interval = PERIOD+1 cycles.
  - 5 CTRL (rw): bit0 run, bit1 oneshot, bit2 irq_en.
  - 6 STATUS: bit0 tick_flag; write 1 clears it.
  - 7: reserved.
- SET, CLR and address 7 read as 0. Unused upper bits of every register read as 0; writes to them are ignored.
- Timer states:
  - IDLE (run=0): counter holds its value.
  - RUN: counter decrements each cycle. At 0 it produces a one-cycle tick and reloads PERIOD.
- IDLE→RUN: a CTRL write with run=1 from IDLE loads counter=PERIOD.
- RUN→IDLE on either of:
  - a CTRL write with run=0;
  - a tick while oneshot=1, in which case hardware clears run in the same cycle as the tick.
- A CTRL write with run=1 while already RUN does not reload the counter. Oneshot and irq_en are updated.
- A PERIOD write while RUN takes effect at the next reload, not immediately.
- On each tick: data_out ^= TMASK and tick_flag is set.
- Simultaneous events:
  - DATA/SET/CLR write in the same cycle as a tick: the bus write result is taken and that cycle's toggle is dropped. tick_flag is still set.
  - STATUS clear in the same cycle as a tick: the set wins, so tick_flag stays 1.
  - CTRL run=0 write in the same cycle as a tick: the tick is honoured (toggle applied, flag set), then the timer stops.
- PERIOD=0 ticks every cycle while RUN, giving a clk/2 square wave on masked bits.

## Timing
- Reset values: out_port=RESET_VALUE, TMASK=0, PERIOD=0, CTRL=0, counter=0, tick_flag=0, irq=0.
- readdata has zero wait states and is valid in the same cycle as the address.
- A register write is visible on out_port and readback from the next clock edge.
- First tick comes PERIOD+1 cycles after the CTRL run=1 write edge. The out_port toggle is visible at that edge.
- irq asserts one cycle after tick_flag sets, provided irq_en=1. It deasserts one cycle after the flag clears or irq_en is written 0.
- An asynchronous reset mid-run returns all state to reset values immediately. No tick is emitted during or after reset until run is rewritten.

## Structure
- A shared package `pio_out_timed_pkg` holds:
  - register address constants (ADDR_DATA..ADDR_STATUS);
  - CTRL bit positions (CTRL_RUN, CTRL_ONESHOT, CTRL_IRQEN);
  - STATUS_TICK.
- Sub-module `pio_period_timer` contains the counter, reload logic, run/oneshot handling and tick output, parametrised by CNT_WIDTH.
- The top level holds register decode, data_out update priority, readdata mux and irq.

## Test plan
- Reset with RESET_VALUE=8'hA5 → out_port=8'hA5, all reads 0 except DATA=0xA5, irq=0.
- Write DATA=0x0F, SET=0x30, CLR=0x05 → out_port=0x0F, then 0x3F, then 0x3A. Reading SET returns 0.
- TMASK=0x01, PERIOD=3, CTRL=0x1 → bit0 toggles every 4 cycles. After 3 ticks out_port bit0=1 (from 0), STATUS=1.
- CTRL=0x7 with PERIOD=9 → exactly one toggle at cycle 10, run reads 0 afterwards, irq rises one cycle later. Writing STATUS=1 drops irq next cycle.
- PERIOD=1 run: force a SET write on a tick cycle and a STATUS clear on a later tick cycle → SET value is kept with no toggle; tick_flag remains 1.
- Assert reset_n low mid-run with PERIOD=100 → outputs return to reset values asynchronously. No tick for 200 cycles after release.
